// File: rtl/fpu_req_sequencer.sv
// Valid/ready issue sequencer for a fixed-latency pipelined FPU. Tagged results
// are collected into a response FIFO guarded by credits, so none is ever dropped.
module fpu_req_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_rmode,
  input  logic [WIDTH-1:0] req_opa,
  input  logic [WIDTH-1:0] req_opb,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       fpu_op,
  output logic [1:0]       fpu_rmode,
  output logic [WIDTH-1:0] fpu_opa,
  output logic [WIDTH-1:0] fpu_opb,
  input  logic [WIDTH-1:0] fpu_out,
  input  logic [7:0]       fpu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [7:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      done_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic             acc, push, pop, full, illegal;
  logic [CntW-1:0]  inflight_q, inflight_d, count_q, count_d;
  logic [CntW:0]    credits_used;
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  wr_idx, rd_idx;
  logic [15:0]      done_q;

  logic [2:0]       fpu_op_q;
  logic [1:0]       fpu_rmode_q;
  logic [WIDTH-1:0] fpu_opa_q, fpu_opb_q;

  logic [LATENCY-1:0] pipe_vld_q, pipe_ill_q;
  logic [TAG_W-1:0]   pipe_tag_q [LATENCY];

  logic [WIDTH-1:0] mem_data_q  [DEPTH];
  logic [7:0]       mem_flags_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q   [DEPTH];

  // Every accepted request owns a slot until popped, so FIFO space is reserved up front.
  assign credits_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign req_ready    = credits_used < (CntW + 1)'(DEPTH);
  assign acc          = req_valid & req_ready;
  assign illegal      = req_op[2];
  assign push         = pipe_vld_q[LATENCY-1];
  assign pop          = rsp_valid & rsp_ready;

  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);

  assign rsp_valid = count_q != '0;
  assign rsp_data  = rsp_valid ? mem_data_q[rd_idx]  : '0;
  assign rsp_flags = rsp_valid ? mem_flags_q[rd_idx] : '0;
  assign rsp_tag   = rsp_valid ? mem_tag_q[rd_idx]   : '0;
  assign busy      = (inflight_q != '0) || (count_q != '0);
  assign done_cnt  = done_q;

  assign fpu_op    = fpu_op_q;
  assign fpu_rmode = fpu_rmode_q;
  assign fpu_opa   = fpu_opa_q;
  assign fpu_opb   = fpu_opb_q;

  always_comb begin
    inflight_d = inflight_q + CntW'(acc) - CntW'(push);
    count_d    = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_op_q    <= '0;
      fpu_rmode_q <= '0;
      fpu_opa_q   <= '0;
      fpu_opb_q   <= '0;
    end else if (acc) begin
      // Illegal ops still occupy a pipeline slot; feed the FPU a harmless add of zeros.
      fpu_op_q    <= illegal ? 3'd0 : req_op;
      fpu_rmode_q <= req_rmode;
      fpu_opa_q   <= illegal ? '0 : req_opa;
      fpu_opb_q   <= illegal ? '0 : req_opb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_ill_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= acc;
      pipe_ill_q[0] <= illegal;
      pipe_tag_q[0] <= req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_ill_q[i] <= pipe_ill_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        done_q   <= done_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_idx]  <= pipe_ill_q[LATENCY-1] ? '1 : fpu_out;
      mem_flags_q[wr_idx] <= pipe_ill_q[LATENCY-1] ? 8'b0010_0000 : fpu_flags;
      mem_tag_q[wr_idx]   <= pipe_tag_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Randomised bench for fpu_req_sequencer: a stand-in FPU feeds results back and a
// queue-based scoreboard predicts credits, response timing, order and contents.
module tb_fpu_req_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [2:0]       req_op = '0;
  logic [1:0]       req_rmode = '0;
  logic [WIDTH-1:0] req_opa = '0, req_opb = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [2:0]       fpu_op;
  logic [1:0]       fpu_rmode;
  logic [WIDTH-1:0] fpu_opa, fpu_opb, fpu_out;
  logic [7:0]       fpu_flags;
  logic             rsp_valid, rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic [7:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [15:0]      done_cnt;

  always #5 clk = ~clk;

  fpu_req_sequencer #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rmode(req_rmode),
    .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy), .done_cnt(done_cnt)
  );

  // Stand-in FPU: single precision via double arithmetic, flags are a rmode/op-dependent hash.
  function automatic real sp2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:23] == 8'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e <= 896) return {d[63], 31'b0};
    if (e >= 1151) return {d[63], 8'hFF, 23'b0};
    return {d[63], 8'(e - 896), d[51:29]};
  endfunction

  function automatic logic [39:0] fpu_pack(input logic [2:0] op, input logic [1:0] rm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o;
    case (op)
      3'd0:    o = r2sp(sp2r(a) + sp2r(b));
      3'd1:    o = r2sp(sp2r(a) - sp2r(b));
      3'd2:    o = r2sp(sp2r(a) * sp2r(b));
      3'd3:    o = (sp2r(b) == 0.0) ? 32'h7F80_0000 : r2sp(sp2r(a) / sp2r(b));
      default: o = '0;
    endcase
    return {o, o[7:0] ^ {op, 3'b000, rm}};
  endfunction

  logic [39:0] hist [LATENCY-1];
  always @(posedge clk) begin
    hist[0] <= fpu_pack(fpu_op, fpu_rmode, fpu_opa, fpu_opb);
    for (int i = 1; i < LATENCY - 1; i++) hist[i] <= hist[i-1];
  end
  assign {fpu_out, fpu_flags} = hist[LATENCY-2];

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  flags;
    logic [3:0]  tag;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  logic [15:0] done_m = '0;
  logic [2:0]  m_op = '0;
  logic [1:0]  m_rmode = '0;
  logic [31:0] m_opa = '0, m_opb = '0;
  int          n_checks = 0, n_errors = 0, acc_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  task automatic set_req(input logic v, input logic [2:0] op, input logic [3:0] tag);
    req_valid = v;
    req_op    = op;
    req_rmode = 2'($urandom_range(0, 3));
    req_opa   = rand_fp();
    req_opb   = rand_fp();
    req_tag   = tag;
  endtask

  task automatic tick();
    logic a, p, v;
    exp_t e;
    @(negedge clk);
    v = (sbq.size() != 0) && ((cyc - sbq[0].acc_cyc) >= LATENCY);
    chk("req_ready", 64'(req_ready), 64'(sbq.size() < DEPTH));
    chk("rsp_valid", 64'(rsp_valid), 64'(v));
    chk("busy", 64'(busy), 64'(sbq.size() != 0));
    chk("done_cnt", 64'(done_cnt), 64'(done_m));
    chk("fpu_op_rmode", 64'({fpu_op, fpu_rmode}), 64'({m_op, m_rmode}));
    chk("fpu_opa", 64'(fpu_opa), 64'(m_opa));
    chk("fpu_opb", 64'(fpu_opb), 64'(m_opb));
    chk("push_into_full", 64'(dut.push & dut.full), 64'(0));
    if (v) begin
      chk("rsp_data", 64'(rsp_data), 64'(sbq[0].data));
      chk("rsp_flags", 64'(rsp_flags), 64'(sbq[0].flags));
      chk("rsp_tag", 64'(rsp_tag), 64'(sbq[0].tag));
    end
    if (req_valid && req_ready) acc_seen++;
    a = req_valid && (sbq.size() < DEPTH);
    p = v && rsp_ready;
    @(posedge clk);
    cyc++;
    if (p) begin
      void'(sbq.pop_front());
      done_m++;
    end
    if (a) begin
      e.tag     = req_tag;
      e.acc_cyc = cyc;
      if (req_op > 3'd3) begin
        e.data = '1;
        e.flags = 8'h20;
        m_op = '0;
        m_opa = '0;
        m_opb = '0;
      end else begin
        {e.data, e.flags} = fpu_pack(req_op, req_rmode, req_opa, req_opb);
        m_op = req_op;
        m_opa = req_opa;
        m_opb = req_opb;
      end
      m_rmode = req_rmode;
      sbq.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_fpu_op", 64'(fpu_op), 64'(0));
    sbq.delete();
    done_m = '0;
    m_op = '0;
    m_rmode = '0;
    m_opa = '0;
    m_opb = '0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (sbq.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    tick();
    chk("drain_empty", 64'(sbq.size()), 64'(0));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, spur, g;
    @(posedge clk);
    #1;
    do_reset();

    // Single op: 1.0 + 2.0 = 3.0
    rsp_ready = 1'b0;
    set_req(1'b1, 3'd0, 4'd5);
    req_opa = 32'h3F80_0000;
    req_opb = 32'h4000_0000;
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    chk("single_latency", 64'(n), 64'(LATENCY));
    chk("single_data", 64'(rsp_data), 64'(32'h4040_0000));
    chk("single_tag", 64'(rsp_tag), 64'(5));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single_done_cnt", 64'(done_cnt), 64'(1));

    // Back-to-back with a ready consumer
    rsp_ready = 1'b1;
    acc_seen = 0;
    for (int i = 0; i < 20; i++) begin
      set_req(1'b1, 3'($urandom_range(0, 3)), 4'(i));
      tick();
    end
    chk("b2b_accepts", 64'(acc_seen), 64'(20));
    drain();

    // Backpressure: exactly DEPTH accepts, then one more after a single pop
    rsp_ready = 1'b0;
    acc_seen = 0;
    for (int i = 0; i < int'(DEPTH + LATENCY + 4); i++) begin
      set_req(1'b1, 3'($urandom_range(0, 7)), 4'(i));
      tick();
    end
    chk("bp_accepts", 64'(acc_seen), 64'(DEPTH));
    chk("bp_ready_low", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_after_pop", 64'(req_ready), 64'(1));
    for (int i = 0; i < 4; i++) tick();
    chk("bp_one_more_accept", 64'(acc_seen), 64'(DEPTH + 1));
    drain();

    // Illegal op
    rsp_ready = 1'b0;
    set_req(1'b1, 3'd6, 4'd3);
    tick();
    req_valid = 1'b0;
    chk("ill_fpu_op", 64'(fpu_op), 64'(0));
    chk("ill_fpu_opa", 64'(fpu_opa), 64'(0));
    wait_rsp(n);
    chk("ill_data", 64'(rsp_data), 64'(32'hFFFF_FFFF));
    chk("ill_flags", 64'(rsp_flags), 64'(8'h20));
    chk("ill_tag", 64'(rsp_tag), 64'(3));
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      set_req(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 4'($urandom));
      rsp_ready = 1'($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    // Reset with 2 queued and 3 in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 3'd2, 4'(i));
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < int'(LATENCY) + 1; i++) tick();
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 3'd1, 4'(i + 8));
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_outstanding", 64'(sbq.size()), 64'(5));
    do_reset();
    rsp_ready = 1'b1;
    spur = 0;
    for (int i = 0; i < int'(2 * LATENCY); i++) begin
      tick();
      if (rsp_valid) spur++;
    end
    chk("rst_no_spurious", 64'(spur), 64'(0));

    // done_cnt wrap
    rsp_ready = 1'b1;
    g = 0;
    while (done_m != 16'hFFFE && g < 70000) begin
      set_req(1'b1, 3'($urandom_range(0, 3)), 4'($urandom));
      tick();
      g++;
    end
    chk("wrap_fffe", 64'(done_cnt), 64'(16'hFFFE));
    tick();
    chk("wrap_ffff", 64'(done_cnt), 64'(16'hFFFF));
    tick();
    chk("wrap_zero", 64'(done_cnt), 64'(16'h0000));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
